// File: rtl/fuzzy_sched_pkg.sv
// Shared types and helpers for the fuzzy risk engine channel scheduler.
// The scheduler FSM state, the engine's risk domain limit and the operand
// clamp used before operands are handed to the engine.

package fuzzy_sched_pkg;

  // Scheduler FSM: wait for a grant, wait out the engine, hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Upper limit of the engine's input domain (percent).
  localparam logic [7:0] RISK_MAX = 8'd100;

  // Saturate an 8-bit sensor reading into the engine domain 0..100.
  function automatic logic [7:0] clamp100(input logic [7:0] value);
    return (value > RISK_MAX) ? RISK_MAX : value;
  endfunction

endpackage

// File: rtl/fuzzy_rr_arb.sv
// Round-robin arbiter for the fuzzy channel scheduler.
// Searches req starting one past ptr, wrapping, and returns the first
// requester both as a one-hot vector and as an index. Purely combinational;
// the caller owns the pointer register.

module fuzzy_rr_arb
  import fuzzy_sched_pkg::*;
#(
  parameter int NCH = 4,
  localparam int IW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] grant_oh,
  output logic [IW-1:0]  grant_idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk the channels in priority order ptr+1, ptr+2, ... and take the first hit.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = IW'((int'(ptr) + i) % NCH);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/fuzzy_chan_sched.sv
// Time-shares one fuzzy risk engine among NCH rainfall/soil sensor channels.
// A round-robin grant selects a channel, its operands are clamped into the
// engine domain and registered onto eng_rain/eng_soil, the engine latency is
// counted out, and the risk is returned tagged with the channel number.
// Optional feature: define FUZZY_SCHED_ALARM_EN to add per-channel alarm
// flags (ports alarm_thresh and alarm) updated on each response handshake.

module fuzzy_chan_sched
  import fuzzy_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int ENG_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          req_valid,
  output logic [NCH-1:0]          req_ready,
  input  logic [NCH*8-1:0]        req_rain,
  input  logic [NCH*8-1:0]        req_soil,
  output logic [7:0]              eng_rain,
  output logic [7:0]              eng_soil,
  input  logic [7:0]              eng_risk,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NCH)-1:0]  rsp_chan,
  output logic [7:0]              rsp_risk,
  output logic                    busy
`ifdef FUZZY_SCHED_ALARM_EN
  ,
  input  logic [7:0]              alarm_thresh,
  output logic [NCH-1:0]          alarm
`endif
);

  localparam int IW = $clog2(NCH);
  localparam int CW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic [NCH-1:0]  grant_oh;
  logic [IW-1:0]   grant_idx;
  logic            xfer;
  logic [7:0]      sel_rain;
  logic [7:0]      sel_soil;

  fuzzy_rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  // Grants are only offered while idle and never while reset is held.
  assign req_ready = (rst_n && state == IDLE) ? grant_oh : '0;
  assign xfer      = (state == IDLE) && (|(req_valid & req_ready));
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Pick the granted channel's operands out of the packed request buses.
  always_comb begin
    sel_rain = '0;
    sel_soil = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant_idx == IW'(c)) begin
        sel_rain = req_rain[c*8 +: 8];
        sel_soil = req_soil[c*8 +: 8];
      end
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE job cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (xfer)        next_state = WAIT;
      WAIT:    if (cnt == '0)   next_state = RESP;
      RESP:    if (rsp_ready)   next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath: launch operands on transfer, count latency, capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= IW'(NCH - 1);
      cnt      <= '0;
      eng_rain <= '0;
      eng_soil <= '0;
      rsp_risk <= '0;
      rsp_chan <= '0;
    end else begin
      if (xfer) begin
        eng_rain <= clamp100(sel_rain);
        eng_soil <= clamp100(sel_soil);
        cnt      <= CW'(ENG_LAT - 1);
        rr_ptr   <= grant_idx;
      end
      if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_risk <= eng_risk;
          rsp_chan <= rr_ptr;
        end
      end
    end
  end

`ifdef FUZZY_SCHED_ALARM_EN
  logic rsp_fire;

  assign rsp_fire = (state == RESP) && rsp_ready;

  // Alarm per channel tracks whether its latest delivered risk met the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= '0;
    end else if (rsp_fire) begin
      alarm[rsp_chan] <= (rsp_risk >= alarm_thresh);
    end
  end
`else
  // Alarm flags are not built; the scheduler core is unchanged.
`endif

endmodule
